lsu_ctrl: RTL and testbench

- Initiator-side load/store controller that sits between the MEM pipeline stage and the port-B data interface of the unified memory/MMIO block.
- Accepts one load/store request at a time from the pipeline.
- Checks alignment, then drives the memory port (ldst code, address, write data, write enable) for a fixed number of cycles. This guarantees the memory's internal write window (one cycle in every four) is hit, and that read data has settled.
- Returns load data or completion to the pipeline with a stall/response handshake.

---
 rtl/lsu_ctrl_pkg.sv | 30 +++
 rtl/lsu_ctrl_if.sv | 33 +++
 rtl/lsu_ctrl.sv | 99 +++++++++
 tb/tb_lsu_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared load/store op codes and small decode helpers for the core.
package lsu_ctrl_pkg;

  localparam int LDST_W = 4;
  typedef logic [LDST_W-1:0] ldst_t;

  localparam ldst_t LDST_NONE = 4'h0;
  localparam ldst_t LDST_LW   = 4'h1;
  localparam ldst_t LDST_LH   = 4'h2;
  localparam ldst_t LDST_LHU  = 4'h3;
  localparam ldst_t LDST_LB   = 4'h4;
  localparam ldst_t LDST_LBU  = 4'h5;
  localparam ldst_t LDST_SW   = 4'h6;
  localparam ldst_t LDST_SH   = 4'h7;
  localparam ldst_t LDST_SB   = 4'h8;

  function automatic logic is_store(ldst_t op);
    return (op == LDST_SW) || (op == LDST_SH) || (op == LDST_SB);
  endfunction

  // Word ops need a 4-byte boundary, halfword ops a 2-byte one; bytes always fit.
  function automatic logic is_misaligned(ldst_t op, logic [1:0] a);
    case (op)
      LDST_LW, LDST_SW:          return a != 2'b00;
      LDST_LH, LDST_LHU, LDST_SH: return a[0];
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Pipeline request/response handshake plus memory port-B signals.
interface lsu_ctrl_if;
  import lsu_ctrl_pkg::*;

  logic        req_valid;
  ldst_t       req_ldst;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  ldst_t       mem_ldst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  // Pipeline / memory model side.
  modport master (
    output req_valid, req_ldst, req_addr, req_wdata, mem_rdata,
    input  req_ready, stall, resp_valid, resp_rdata, resp_misalign,
           mem_ldst, mem_addr, mem_wdata, mem_we
  );

  // Controller side.
  modport slave (
    input  req_valid, req_ldst, req_addr, req_wdata, mem_rdata,
    output req_ready, stall, resp_valid, resp_rdata, resp_misalign,
           mem_ldst, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, alignment check, fixed-length
// drive of memory port B, single-cycle response pulse.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned WR_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  lsu_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR_HOLD, S_DONE} state_t;

  localparam logic [3:0] RD_CNT0 = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_CNT0 = 4'(WR_HOLD - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  ldst_t       op_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        mis_q;
  logic        accept, mis, driving;

  assign accept  = (state == S_IDLE) && bus.req_valid && (bus.req_ldst != LDST_NONE);
  assign mis     = is_misaligned(bus.req_ldst, bus.req_addr[1:0]);
  assign driving = (state == S_RD_WAIT) || (state == S_WR_HOLD);

  // State register; reset abort lands straight in IDLE, dropping every drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and wait counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (mis) begin
            state_nxt = S_DONE;
          end else if (is_store(bus.req_ldst)) begin
            state_nxt = S_WR_HOLD;
            cnt_nxt   = WR_CNT0;
          end else begin
            state_nxt = S_RD_WAIT;
            cnt_nxt   = RD_CNT0;
          end
        end
      end
      S_RD_WAIT, S_WR_HOLD: begin
        if (cnt == 4'd0) state_nxt = S_DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch and load capture. Address/data only move on an aligned
  // accept, so the port keeps its last driven values across a misaligned op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= LDST_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= bus.req_ldst;
        mis_q <= mis;
        if (!mis) begin
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
        end
      end
      if ((state == S_RD_WAIT) && (cnt == 4'd0)) rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.req_ready     = (state == S_IDLE);
  assign bus.stall         = driving || accept;
  assign bus.resp_valid    = (state == S_DONE);
  assign bus.resp_misalign = (state == S_DONE) && mis_q;
  assign bus.resp_rdata    = rdata_q;
  assign bus.mem_ldst      = driving ? op_q : LDST_NONE;
  assign bus.mem_we        = (state == S_WR_HOLD);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table for single ops, hand sequences
// for back-to-back, reset abort and NONE requests.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  lsu_ctrl_if bus();

  lsu_ctrl #(.RD_LAT(2), .WR_HOLD(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    ldst_t       ldst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          exp_resp;   // cycle of resp_valid, acceptance = 0
    int          exp_we;     // number of mem_we cycles
    logic        exp_mis;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[8];
  int n_chk = 0;
  int n_fail = 0;
  int resp_cyc, we_cnt, we_first, we_last, drv_bad, stall_bad, ld_first, overlap, bad;
  logic [31:0] got_rdata;
  logic        got_mis, drive;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{LDST_LW,  32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 3, 0, 1'b0, 32'hDEAD_BEEF};
    vt[1] = '{LDST_SB,  32'h0000_0013, 32'h0000_00AB,  32'h1111_1111, 5, 4, 1'b0, 32'hDEAD_BEEF};
    vt[2] = '{LDST_LW,  32'h0000_0002, 32'h0,          32'h2222_2222, 1, 0, 1'b1, 32'hDEAD_BEEF};
    vt[3] = '{LDST_SH,  32'h0000_0005, 32'h0000_5555,  32'h3333_3333, 1, 0, 1'b1, 32'hDEAD_BEEF};
    vt[4] = '{LDST_LB,  32'h0000_0003, 32'h0,          32'h0000_007F, 3, 0, 1'b0, 32'h0000_007F};
    vt[5] = '{LDST_LHU, 32'hFFFF_0002, 32'h0,          32'h0000_BEEF, 3, 0, 1'b0, 32'h0000_BEEF};
    vt[6] = '{LDST_SW,  32'h0000_0008, 32'hA5A5_5A5A,  32'h4444_4444, 5, 4, 1'b0, 32'h0000_BEEF};
    vt[7] = '{LDST_LH,  32'h0000_0006, 32'h0,          32'hFFFF_8000, 3, 0, 1'b0, 32'hFFFF_8000};

    bus.req_valid = 1'b0;
    bus.req_ldst  = LDST_NONE;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_rdata = '0;

    // Reset values.
    #1;
    chk("rst resp_valid", 32'(bus.resp_valid), 0);
    chk("rst resp_misalign", 32'(bus.resp_misalign), 0);
    chk("rst resp_rdata", bus.resp_rdata, 0);
    chk("rst mem_we", 32'(bus.mem_we), 0);
    chk("rst mem_ldst", 32'(bus.mem_ldst), 32'(LDST_NONE));
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst mem_wdata", bus.mem_wdata, 0);
    chk("rst req_ready", 32'(bus.req_ready), 1);
    chk("rst stall", 32'(bus.stall), 0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;

    // Single-op vectors.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_ldst  = vt[i].ldst;
      bus.req_addr  = vt[i].addr;
      bus.req_wdata = vt[i].wdata;
      bus.mem_rdata = vt[i].rdata;
      resp_cyc = -1; we_cnt = 0; we_first = -1; drv_bad = 0; stall_bad = 0;
      got_rdata = 'x; got_mis = 1'bx;
      for (int c = 0; c < 20 && resp_cyc < 0; c++) begin
        @(negedge clk);
        drive = (c >= 1) && (c < vt[i].exp_resp) && !vt[i].exp_mis;
        if (drive) begin
          if (bus.mem_ldst !== vt[i].ldst || bus.mem_addr !== vt[i].addr) drv_bad++;
          if (vt[i].exp_we > 0 && bus.mem_wdata !== vt[i].wdata) drv_bad++;
        end else if (bus.mem_ldst !== LDST_NONE) drv_bad++;
        if (bus.mem_we === 1'b1) begin
          we_cnt++;
          if (we_first < 0) we_first = c;
        end
        if (bus.stall !== (c < vt[i].exp_resp)) stall_bad++;
        if (bus.resp_valid === 1'b1) begin
          resp_cyc  = c;
          got_rdata = bus.resp_rdata;
          got_mis   = bus.resp_misalign;
        end
        @(posedge clk); #1;
        if (c == 0) bus.req_valid = 1'b0;
      end
      chk($sformatf("v%0d resp cycle", i), resp_cyc, vt[i].exp_resp);
      chk($sformatf("v%0d we cycles", i), we_cnt, vt[i].exp_we);
      chk($sformatf("v%0d we first", i), we_first, (vt[i].exp_we > 0) ? 1 : -1);
      chk($sformatf("v%0d port drive errs", i), drv_bad, 0);
      chk($sformatf("v%0d stall errs", i), stall_bad, 0);
      chk($sformatf("v%0d misalign", i), 32'(got_mis), 32'(vt[i].exp_mis));
      chk($sformatf("v%0d rdata", i), got_rdata, vt[i].exp_rdata);
    end

    // Store then load, req_valid held high; load switched in during DONE.
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_ldst  = LDST_SW;
    bus.req_addr  = 32'h0000_0020;
    bus.req_wdata = 32'h1234_5678;
    bus.mem_rdata = 32'hCAFE_F00D;
    ld_first = -1; overlap = 0; resp_cyc = -1; we_last = -1; got_rdata = 'x;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 5) begin
        chk("b2b done ready", 32'(bus.req_ready), 0);
        chk("b2b done stall", 32'(bus.stall), 0);
        chk("b2b store resp", 32'(bus.resp_valid), 1);
      end
      if (c == 6) begin
        chk("b2b accept ready", 32'(bus.req_ready), 1);
        chk("b2b accept stall", 32'(bus.stall), 1);
      end
      if (bus.mem_we === 1'b1) we_last = c;
      if (bus.mem_ldst === LDST_LW) begin
        if (ld_first < 0) ld_first = c;
        if (bus.mem_we !== 1'b0) overlap++;
      end
      if (c > 5 && bus.resp_valid === 1'b1 && resp_cyc < 0) begin
        resp_cyc  = c;
        got_rdata = bus.resp_rdata;
      end
      @(posedge clk); #1;
      if (c == 4) begin
        bus.req_ldst = LDST_LW;
        bus.req_addr = 32'h0000_0024;
      end
      if (c == 6) bus.req_valid = 1'b0;
    end
    chk("b2b we last", we_last, 4);
    chk("b2b load drive first", ld_first, 7);
    chk("b2b we/load overlap", overlap, 0);
    chk("b2b load resp cycle", resp_cyc, 9);
    chk("b2b load rdata", got_rdata, 32'hCAFE_F00D);

    // Reset during a store.
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_ldst  = LDST_SW;
    bus.req_addr  = 32'h0000_0030;
    bus.req_wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort pre we", 32'(bus.mem_we), 1);
    #1 rst = 1'b1;
    #1;
    chk("abort we drop", 32'(bus.mem_we), 0);
    chk("abort ldst drop", 32'(bus.mem_ldst), 32'(LDST_NONE));
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_we !== 1'b0) bad++;
    end
    chk("abort no resp, ready", bad, 0);

    // req_valid with NONE is ignored.
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_ldst  = LDST_NONE;
    bus.req_addr  = 32'h0000_0040;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.stall !== 1'b0 || bus.req_ready !== 1'b1 ||
          bus.mem_ldst !== LDST_NONE || bus.resp_valid !== 1'b0) bad++;
    end
    chk("none ignored", bad, 0);
    chk("none ready", 32'(bus.req_ready), 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
